// File: rtl/pipeline_ctrl.sv
// Sequencing and hazard controller for the 5-stage pipeline: run/step/drain/halt
// FSM plus load-use stall, branch flush and enabled-cycle counting.
module pipeline_ctrl #(
    parameter int RBITS        = 5,
    parameter int CBITS        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step_mode,
    input  logic             i_step,
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic             ID_haltflag,
    input  logic             ID_branch_taken,
    input  logic             EX_memread,
    input  logic [RBITS-1:0] EX_rt,
    output logic             o_pipe_en,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_nop,
    output logic             o_halted,
    output logic [2:0]       o_state,
    output logic [CBITS-1:0] o_cycle_count
);

    localparam int DBITS = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t           state;
    logic [DBITS-1:0] drain_cnt;
    logic             step_pending;
    logic             step_d;
    logic [CBITS-1:0] cycle_cnt;

    logic load_use;
    logic exec_en;
    logic pipe_en;
    logic halt_accept;

    // exec_en marks cycles where a new instruction may advance; DRAIN only retires.
    always_comb begin
        load_use    = EX_memread && (EX_rt != '0) && ((EX_rt == ID_rs) || (EX_rt == ID_rt));
        exec_en     = (state == RUN) || ((state == STEP) && step_pending);
        pipe_en     = exec_en || (state == DRAIN);
        halt_accept = exec_en && ID_haltflag && !load_use;

        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_nop   = 1'b0;
        if (exec_en) begin
            if (load_use) begin
                o_idex_nop = 1'b1;
            end else begin
                o_pc_write   = 1'b1;
                o_ifid_write = 1'b1;
                o_ifid_flush = ID_branch_taken;
            end
        end else if (state == DRAIN) begin
            o_ifid_flush = 1'b1;
            o_idex_nop   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            step_pending <= 1'b0;
            step_d       <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            step_d <= i_step;
            if (pipe_en)
                cycle_cnt <= cycle_cnt + 1'b1;

            case (state)
                IDLE: begin
                    step_pending <= 1'b0;
                    if (i_start)
                        state <= i_step_mode ? STEP : RUN;
                end
                RUN: begin
                    if (halt_accept) begin
                        state     <= DRAIN;
                        drain_cnt <= DBITS'(DRAIN_CYCLES);
                    end
                end
                STEP: begin
                    // A pending step is consumed before any new edge is considered.
                    if (step_pending)
                        step_pending <= 1'b0;
                    else if (i_step && !step_d)
                        step_pending <= 1'b1;
                    if (halt_accept) begin
                        state     <= DRAIN;
                        drain_cnt <= DBITS'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    step_pending <= 1'b0;
                    drain_cnt    <= drain_cnt - 1'b1;
                    if (drain_cnt == DBITS'(1))
                        state <= HALT;
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_pipe_en     = pipe_en;
    assign o_halted      = (state == HALT);
    assign o_state       = state;
    assign o_cycle_count = cycle_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued per step
// and compared at the falling edge of the cycle they describe.
module tb_pipeline_ctrl;

    localparam int RBITS = 5;
    localparam int CBITS = 32;

    // {pipe_en, pc_write, ifid_write, ifid_flush, idex_nop, halted}
    localparam logic [5:0] V_OFF   = 6'b000000;
    localparam logic [5:0] V_RUN   = 6'b111000;
    localparam logic [5:0] V_STALL = 6'b100010;
    localparam logic [5:0] V_BR    = 6'b111100;
    localparam logic [5:0] V_DRN   = 6'b100110;
    localparam logic [5:0] V_HLT   = 6'b000001;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic             i_step_mode;
    logic             i_step;
    logic [RBITS-1:0] ID_rs;
    logic [RBITS-1:0] ID_rt;
    logic             ID_haltflag;
    logic             ID_branch_taken;
    logic             EX_memread;
    logic [RBITS-1:0] EX_rt;
    logic             o_pipe_en;
    logic             o_pc_write;
    logic             o_ifid_write;
    logic             o_ifid_flush;
    logic             o_idex_nop;
    logic             o_halted;
    logic [2:0]       o_state;
    logic [CBITS-1:0] o_cycle_count;

    pipeline_ctrl #(
        .RBITS(RBITS),
        .CBITS(CBITS),
        .DRAIN_CYCLES(3)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_step_mode(i_step_mode),
        .i_step(i_step),
        .ID_rs(ID_rs),
        .ID_rt(ID_rt),
        .ID_haltflag(ID_haltflag),
        .ID_branch_taken(ID_branch_taken),
        .EX_memread(EX_memread),
        .EX_rt(EX_rt),
        .o_pipe_en(o_pipe_en),
        .o_pc_write(o_pc_write),
        .o_ifid_write(o_ifid_write),
        .o_ifid_flush(o_ifid_flush),
        .o_idex_nop(o_idex_nop),
        .o_halted(o_halted),
        .o_state(o_state),
        .o_cycle_count(o_cycle_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0]       bits;
        logic [2:0]       st;
        logic [CBITS-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    logic [CBITS-1:0] exp_cnt = '0;

    task automatic expect_out(input logic [5:0] b, input logic [2:0] s);
        exp_t e;
        e.bits = b;
        e.st   = s;
        e.cnt  = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t       e;
        logic [5:0] obs;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e   = sb.pop_front();
        obs = {o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush, o_idex_nop, o_halted};
        total++;
        assert (obs === e.bits) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e.bits);
        end
        total++;
        assert (o_state === e.st) else begin
            bad++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, o_state, e.st);
        end
        total++;
        assert (o_cycle_count === e.cnt) else begin
            bad++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, o_cycle_count, e.cnt);
        end
        // The counter advances at the edge closing an enabled cycle.
        if (e.bits[5])
            exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic cyc(input string tag, input logic [5:0] b, input logic [2:0] s);
        expect_out(b, s);
        @(negedge i_clk);
        compare(tag);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0;
        ID_rs = '0; ID_rt = '0; ID_haltflag = 1'b0; ID_branch_taken = 1'b0;
        EX_memread = 1'b0; EX_rt = '0;
        @(posedge i_clk);
        #1;

        cyc("reset", V_OFF, 3'd0);
        i_rst = 1'b0;
        cyc("idle", V_OFF, 3'd0);
        i_start = 1'b1;
        cyc("idle_start", V_OFF, 3'd0);
        i_start = 1'b0;
        for (int i = 0; i < 10; i++) cyc("run", V_RUN, 3'd1);

        i_step_mode = 1'b1;
        EX_memread = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; ID_rt = 5'd9;
        cyc("load_use_rs", V_STALL, 3'd1);
        EX_rt = 5'd0; ID_rs = 5'd0;
        cyc("load_r0", V_RUN, 3'd1);
        EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; ID_branch_taken = 1'b1; ID_haltflag = 1'b1;
        cyc("load_use_br_halt", V_STALL, 3'd1);
        EX_memread = 1'b0; ID_haltflag = 1'b0;
        cyc("branch", V_BR, 3'd1);
        ID_branch_taken = 1'b0;
        cyc("no_load_match", V_RUN, 3'd1);
        ID_haltflag = 1'b1; ID_rt = 5'd1;
        cyc("halt_accept", V_RUN, 3'd1);
        ID_haltflag = 1'b0; ID_branch_taken = 1'b1; EX_memread = 1'b1; EX_rt = 5'd3;
        for (int i = 0; i < 3; i++) cyc("drain", V_DRN, 3'd3);
        ID_branch_taken = 1'b0; EX_memread = 1'b0;
        i_start = 1'b1;
        cyc("halt", V_HLT, 3'd4);
        i_step = 1'b1; i_step_mode = 1'b0;
        cyc("halt_hold", V_HLT, 3'd4);
        i_step = 1'b0;
        cyc("halt_hold2", V_HLT, 3'd4);
        i_start = 1'b0;

        // Restart in single-step mode.
        i_rst = 1'b1;
        exp_cnt = '0;
        #1;
        expect_out(V_OFF, 3'd0);
        compare("rst_from_halt");
        i_rst = 1'b0;
        i_step_mode = 1'b1; i_start = 1'b1;
        cyc("step_enter", V_OFF, 3'd0);
        i_start = 1'b0; i_step_mode = 1'b0;
        cyc("step_wait", V_OFF, 3'd2);
        i_step = 1'b1;
        cyc("step_edge", V_OFF, 3'd2);
        cyc("step_pulse", V_RUN, 3'd2);
        for (int i = 0; i < 3; i++) cyc("step_held", V_OFF, 3'd2);
        i_step = 1'b0;
        cyc("step_low", V_OFF, 3'd2);
        i_step = 1'b1;
        cyc("step2_edge", V_OFF, 3'd2);
        i_step = 1'b0;
        cyc("step2_pulse", V_RUN, 3'd2);
        i_step = 1'b1;
        cyc("step3_edge", V_OFF, 3'd2);
        cyc("step3_pulse", V_RUN, 3'd2);
        i_step = 1'b0;
        cyc("step3_after", V_OFF, 3'd2);
        i_step = 1'b1;
        cyc("step4_edge", V_OFF, 3'd2);
        i_step = 1'b0; EX_memread = 1'b1; EX_rt = 5'd4; ID_rs = 5'd4; ID_haltflag = 1'b1;
        cyc("step4_stall", V_STALL, 3'd2);
        EX_memread = 1'b0;
        cyc("step4_idle", V_OFF, 3'd2);
        i_step = 1'b1;
        cyc("step5_edge", V_OFF, 3'd2);
        i_step = 1'b0;
        cyc("step5_halt", V_RUN, 3'd2);
        ID_haltflag = 1'b0;
        for (int i = 0; i < 3; i++) cyc("step_drain", V_DRN, 3'd3);
        cyc("step_halted", V_HLT, 3'd4);

        // Reset in the middle of DRAIN.
        i_rst = 1'b1;
        exp_cnt = '0;
        #1;
        i_rst = 1'b0;
        i_start = 1'b1;
        cyc("run2_enter", V_OFF, 3'd0);
        i_start = 1'b0;
        cyc("run2", V_RUN, 3'd1);
        ID_haltflag = 1'b1;
        cyc("run2_halt", V_RUN, 3'd1);
        ID_haltflag = 1'b0;
        cyc("run2_drain1", V_DRN, 3'd3);
        i_rst = 1'b1;
        exp_cnt = '0;
        #1;
        expect_out(V_OFF, 3'd0);
        compare("rst_mid_drain");
        @(negedge i_clk);
        expect_out(V_OFF, 3'd0);
        compare("rst_held");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
